spi_frame_receiver: RTL and testbench
=====================================

Name: spi_frame_receiver

Overview:
- SPI slave that receives one 48-bit configuration frame from the MCU and presents it as a single flattened word.
- Sits directly upstream of the signal-splitting stage. Its frame_data output drives that stage's 48-bit flattened input.
- Byte 0 is the first byte sent and lands in [47:40]; the splitter maps it to sd0.
- Registers a frame only when exactly FRAME_BITS bits arrived between chip-select assertion and deassertion. Otherwise it flags an error and keeps the previous frame.

Parameters:
- FRAME_BITS, 48, bits per valid frame; also the frame_data width.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sck, sdi and cs_n (minimum 2).
- CNT_W, 6, bit counter width; must hold FRAME_BITS+1.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- nreset  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0; frequency at most clk/8.
- sdi  input  1  SPI data from MCU, MSB first, stable around the sck rising edge.
- cs_n  input  1  SPI chip select from MCU, active-low, frames one transfer.
- frame_data  output  FRAME_BITS  last good frame, held until the next good frame.
- frame_valid  output  1  one-clk pulse: frame_data was updated this cycle.
- frame_err  output  1  one-clk pulse: frame ended with a bit count other than FRAME_BITS.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (nreset low, async): frame_data=0, frame_valid=0, frame_err=0, busy=0, state=IDLE, counter=0, shift register=0, synchronizers=all ones (models idle-high cs_n and sck).
- Synchronization:
  - sck, sdi and cs_n each pass through SYNC_STAGES flops, so all three see equal delay.
  - sck_rise = synced sck high and its previous synced value low.
  - cs_fall and cs_rise are derived the same way from synced cs_n.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE: on cs_fall, clear counter and shift register, go to SHIFT.
  - IDLE: sck activity is ignored.
  - IDLE: cs_n already low with no fall seen (low at reset release) stays in IDLE.
  - SHIFT: on each sck_rise, shift_reg <= {shift_reg[FRAME_BITS-2:0], synced sdi}.
  - SHIFT: on each sck_rise, counter increments and saturates at FRAME_BITS+1.
  - SHIFT: on cs_rise, go to DONE.
  - SHIFT: if sck_rise and cs_rise occur in the same cycle, the bit is shifted and counted before the frame is judged.
  - DONE, counter==FRAME_BITS: frame_data <= shift_reg, frame_valid=1 for this cycle.
  - DONE, otherwise: frame_err=1 for this cycle; frame_data unchanged.
  - DONE: always go to IDLE next cycle.
  - DONE: a cs_fall in the DONE cycle is missed; the MCU must hold cs_n high for at least 4 clk cycles between frames.
- Latency: frame_valid asserts SYNC_STAGES+2 clk edges after the first clk edge that samples cs_n high at the pin. With defaults that is 4 edges.
- frame_valid and frame_err are mutually exclusive and never high for more than one consecutive cycle.
- busy = (state==SHIFT), registered.
- Zero-bit frame (cs_n pulse with no sck edges) gives frame_err.
- Overlong frames saturate the counter, so counts above FRAME_BITS never wrap back to a valid value.
- Reset mid-frame aborts the transfer:
  - all state returns to reset values, including frame_data=0;
  - no valid or err pulse is produced;
  - remaining bits of that frame are ignored until a new cs_fall.

Test Plan:
- cs_n low, 48 bits of 0x5566778899AA MSB first, cs_n high -> one frame_valid pulse 4 clk after cs_n rises; frame_data=0x5566778899AA; downstream splitter yields sd0=0x55 and sd5=0xAA.
- Frame of 47 bits of 0x123456789ABC after a good frame 0x5566778899AA -> frame_err pulse, no frame_valid, frame_data stays 0x5566778899AA.
- 49 bits sent, including the case where the 49th sck rise coincides with the cs_n rise at the synchronizer output -> frame_err; 60 bits -> frame_err, no counter wrap.
- Back-to-back frames 0xFFFFFFFFFFFF then 0x000000000001 with 4-clk cs_n high gap -> two frame_valid pulses; final frame_data=0x000000000001.
- nreset pulsed low after 20 bits, then a full 48-bit frame 0xA5A5A5A5A5A5 -> no pulse for the aborted frame; frame_data=0 after reset, then 0xA5A5A5A5A5A5 with one frame_valid.
- cs_n held low through reset release, 48 sck edges, cs_n high -> no frame_valid and no frame_err, busy stays 0; the next proper frame is received normally.

Source files
------------

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave that captures one FRAME_BITS-wide configuration frame per chip-select window.
// A frame is accepted only if exactly FRAME_BITS sck rising edges arrived while selected.
module spi_frame_receiver #(
  parameter int FRAME_BITS  = 48,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  cs_n,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync, fill;
  logic                   sck_prev, cs_prev, armed;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_rise, cs_rise, cs_fall;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [FRAME_BITS-1:0]  shift_reg, shift_next, data_next;
  logic                   valid_next, err_next;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  // A fall only counts once cs_n has been seen high after reset, so a select
  // that was already low at reset release never opens a frame.
  assign cs_fall  = armed & cs_prev & ~cs_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which keeps the synchronizer chains ordered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sck_sync <= '1;
      sdi_sync <= '1;
      cs_sync  <= '1;
      fill     <= '0;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      armed    <= armed | (fill[SYNC_STAGES-1] & cs_s);
    end
  end

  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift_reg;
    data_next  = frame_data;
    valid_next = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          cnt_next   = '0;
          shift_next = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A bit arriving together with deselect is still counted before judging.
        if (sck_rise) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], sdi_s};
          if (cnt != CNT_MAX) cnt_next = cnt + CNT_W'(1);
        end
        if (cs_rise) state_next = DONE;
      end
      DONE: begin
        if (cnt == CNT_FULL) begin
          data_next  = shift_reg;
          valid_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_reg   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shift_reg   <= shift_next;
      frame_data  <= data_next;
      frame_valid <= valid_next;
      frame_err   <= err_next;
      busy        <= (state_next == SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: expected frame outcomes are queued when a
// frame is driven and compared by a monitor whenever a valid/err pulse appears.
module tb_spi_frame_receiver;

  logic        clk;
  logic        nreset;
  logic        sck;
  logic        sdi;
  logic        cs_n;
  logic [47:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  typedef struct {
    logic        is_err;
    logic [47:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] model_data;
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic        prev_pulse   = 1'b0;

  spi_frame_receiver dut (
    .clk         (clk),
    .nreset      (nreset),
    .sck         (sck),
    .sdi         (sdi),
    .cs_n        (cs_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_valid(input logic [47:0] d);
    exp_t e;
    model_data = d;
    e.is_err   = 1'b0;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = model_data;
    exp_q.push_back(e);
  endtask

  // Sends the low n bits of v MSB first; sck period is 8 clk cycles.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // One complete chip-select window; coincide raises cs_n together with the last sck rise.
  task automatic run_frame(input logic [63:0] v, input int n, input bit coincide, input int gap);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    if (coincide) begin
      send_bits(v >> 1, n - 1);
      sdi = v[0];
      repeat (4) @(negedge clk);
      sck  = 1'b1;
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end else begin
      send_bits(v, n);
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
    end
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_valid || frame_err) begin
      check("pulse_exclusive", 64'(frame_valid & frame_err), 64'd0);
      check("pulse_single", 64'(prev_pulse), 64'd0);
      check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_kind_err", 64'(frame_err), 64'(e.is_err));
        check("pulse_data", 64'(frame_data), 64'(e.data));
      end
    end
    prev_pulse = frame_valid | frame_err;
  end

  initial begin
    logic [63:0] a5;
    a5         = 64'h0000_A5A5_A5A5_A5A5;
    nreset     = 1'b0;
    cs_n       = 1'b1;
    sck        = 1'b0;
    sdi        = 1'b0;
    model_data = '0;

    repeat (3) @(negedge clk);
    check("reset_frame_data", 64'(frame_data), 64'd0);
    check("reset_frame_valid", 64'(frame_valid), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    nreset = 1'b1;
    repeat (6) @(negedge clk);

    // Good frame with latency and splitter view
    push_valid(48'h5566778899AA);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_in_shift", 64'(busy), 64'd1);
    send_bits(64'h5566778899AA, 48);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("latency_early", 64'(frame_valid), 64'd0);
    @(negedge clk);
    check("latency_valid", 64'(frame_valid), 64'd1);
    check("frame1_data", 64'(frame_data), 64'h5566778899AA);
    check("split_sd0", 64'(frame_data[47:40]), 64'h55);
    check("split_sd5", 64'(frame_data[7:0]), 64'hAA);
    @(negedge clk);
    check("pulse_width", 64'(frame_valid), 64'd0);
    check("busy_after_frame", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);

    // Short frame keeps previous data
    push_err();
    run_frame(64'h123456789ABC >> 1, 47, 1'b0, 10);
    check("short_keeps_data", 64'(frame_data), 64'h5566778899AA);

    // Long frames, including last bit coinciding with deselect
    push_err();
    run_frame(64'h0000_0F0F_F0F0_1234, 49, 1'b0, 10);
    push_err();
    run_frame(64'h0001_5566_7788_99AA, 49, 1'b1, 10);
    push_err();
    run_frame(64'h0123_4567_89AB_CDEF, 60, 1'b0, 10);
    check("long_keeps_data", 64'(frame_data), 64'h5566778899AA);

    // Zero-bit frame
    push_err();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);

    // Exactly 48 bits with the last rise coinciding with deselect is still good
    push_valid(48'h0F1E2D3C4B5A);
    run_frame(64'h0F1E2D3C4B5A, 48, 1'b1, 10);
    check("coincide48_data", 64'(frame_data), 64'h0F1E2D3C4B5A);

    // Back-to-back with 4-clk gap
    push_valid(48'hFFFFFFFFFFFF);
    run_frame(64'hFFFF_FFFF_FFFF, 48, 1'b0, 4);
    push_valid(48'h000000000001);
    run_frame(64'h0000_0000_0001, 48, 1'b0, 10);
    check("b2b_final_data", 64'(frame_data), 64'h000000000001);

    // Reset in the middle of a frame
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(a5 >> 28, 20);
    nreset     = 1'b0;
    model_data = '0;
    repeat (2) @(negedge clk);
    check("abort_reset_data", 64'(frame_data), 64'd0);
    nreset = 1'b1;
    send_bits(a5, 28);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_update", 64'(frame_data), 64'd0);
    push_valid(48'hA5A5A5A5A5A5);
    run_frame(a5, 48, 1'b0, 10);
    check("after_abort_data", 64'(frame_data), 64'hA5A5A5A5A5A5);

    // cs_n low through reset release
    nreset = 1'b0;
    cs_n   = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(64'h0000_1357_9BDF_2468, 48);
    check("held_low_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("held_low_busy_after", 64'(busy), 64'd0);
    check("held_low_data", 64'(frame_data), 64'd0);
    push_valid(48'h3C3C5A5A9696);
    run_frame(64'h3C3C_5A5A_9696, 48, 1'b0, 10);
    check("recover_data", 64'(frame_data), 64'h3C3C5A5A9696);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
